// File: rtl/axi4_lite_pkg.sv
// ============================================================================
// Module   : axi4_lite_pkg
// Brief    : Shared types for the AXI4-Lite slave register file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi4_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } w_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    localparam int c_PROT_PRIV_BIT  = 0;
    localparam int c_PROT_SEC_BIT   = 1;
    localparam int c_PROT_INSTR_BIT = 2;

endpackage

`default_nettype wire

// File: rtl/axi4_lite_regfile.sv
// ============================================================================
// Module   : axi4_lite_regfile
// Brief    : Register storage with one byte-strobed write port and one
//            combinational read port; contents exported flattened.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi4_lite_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter int IDX_W      = $clog2(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_we,
    input  logic [IDX_W-1:0]               i_widx,
    input  logic [DATA_WIDTH-1:0]          i_wdata,
    input  logic [DATA_WIDTH/8-1:0]        i_wstrb,
    input  logic [IDX_W-1:0]               i_ridx,
    output logic [DATA_WIDTH-1:0]          o_rdata,
    output logic [NUM_REGS*DATA_WIDTH-1:0] o_regs
);

    localparam int c_NBYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            for (int b = 0; b < c_NBYTES; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_widx][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read sees the pre-write value when read and write coincide.
    assign o_rdata = r_mem[i_ridx];

    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
            assign o_regs[g*DATA_WIDTH +: DATA_WIDTH] = r_mem[g];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/axi4_lite_slave_regs.sv
// ============================================================================
// Module   : axi4_lite_slave_regs
// Brief    : AXI4-Lite slave register file with independent read/write FSMs.
//            Define AXI_LITE_SLV_PROT_EN to reject unprivileged accesses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi4_lite_slave_regs
    import axi4_lite_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int NUM_REGS      = 16
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [ADDRESS_WIDTH-1:0]       AWADDR,
    input  logic [2:0]                     AWPROT,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic [DATA_WIDTH/8-1:0]        WSTRB,
    input  logic                           WVALID,
    output logic                           WREADY,
    output logic [1:0]                     BRESP,
    output logic                           BVALID,
    input  logic                           BREADY,
    input  logic [ADDRESS_WIDTH-1:0]       ARADDR,
    input  logic [2:0]                     ARPROT,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

    localparam int c_STRB_W = DATA_WIDTH / 8;
    localparam int c_OFF_W  = $clog2(c_STRB_W);
    localparam int c_IDX_W  = $clog2(NUM_REGS);
    localparam logic [ADDRESS_WIDTH-1:0] c_ADDR_LIMIT = ADDRESS_WIDTH'(NUM_REGS * c_STRB_W);

    // Write channel state
    w_state_t                 r_wstate, w_wstate_nxt;
    logic                     r_awready, w_awready_nxt;
    logic                     r_wready, w_wready_nxt;
    logic                     r_bvalid, w_bvalid_nxt;
    resp_t                    r_bresp, w_bresp_nxt;
    logic [ADDRESS_WIDTH-1:0] r_awaddr;
    logic [2:0]               r_awprot;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [c_STRB_W-1:0]      r_wstrb;
    logic                     w_aw_hs, w_w_hs, w_we, w_wr_ok, w_wr_prot_ok;

    // Read channel state
    r_state_t                 r_rstate, w_rstate_nxt;
    logic                     r_arready, w_arready_nxt;
    logic                     r_rvalid, w_rvalid_nxt;
    logic [DATA_WIDTH-1:0]    r_rdata, w_rdata_nxt;
    resp_t                    r_rresp, w_rresp_nxt;
    logic [DATA_WIDTH-1:0]    w_rd_word;
    logic                     w_ar_hs, w_rd_ok, w_rd_prot_ok;

`ifdef AXI_LITE_SLV_PROT_EN
    assign w_wr_prot_ok = r_awprot[c_PROT_PRIV_BIT];
    assign w_rd_prot_ok = ARPROT[c_PROT_PRIV_BIT];
`else
    assign w_wr_prot_ok = 1'b1;
    assign w_rd_prot_ok = 1'b1;
`endif

    // Protection bits that never influence behaviour in this build.
    logic w_unused_prot;
    assign w_unused_prot = ^{r_awprot[c_PROT_PRIV_BIT], r_awprot[c_PROT_SEC_BIT],
                             r_awprot[c_PROT_INSTR_BIT], ARPROT};

    assign w_aw_hs = AWVALID && r_awready;
    assign w_w_hs  = WVALID && r_wready;
    assign w_ar_hs = ARVALID && r_arready;
    assign w_wr_ok = (r_awaddr < c_ADDR_LIMIT) && w_wr_prot_ok;
    assign w_rd_ok = (ARADDR < c_ADDR_LIMIT) && w_rd_prot_ok;

    axi4_lite_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .IDX_W      (c_IDX_W)
    ) u_regfile (
        .clk     (ACLK),
        .rst     (ARESET),
        .i_we    (w_we),
        .i_widx  (r_awaddr[c_OFF_W +: c_IDX_W]),
        .i_wdata (r_wdata),
        .i_wstrb (r_wstrb),
        .i_ridx  (ARADDR[c_OFF_W +: c_IDX_W]),
        .o_rdata (w_rd_word),
        .o_regs  (regs_o)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_bvalid  <= 1'b0;
            r_bresp   <= OKAY;
            r_awaddr  <= '0;
            r_awprot  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_awready <= w_awready_nxt;
            r_wready  <= w_wready_nxt;
            r_bvalid  <= w_bvalid_nxt;
            r_bresp   <= w_bresp_nxt;
            if (w_aw_hs) begin
                r_awaddr <= AWADDR;
                r_awprot <= AWPROT;
            end
            if (w_w_hs) begin
                r_wdata <= WDATA;
                r_wstrb <= WSTRB;
            end
        end
    end

    // A low READY marks a captured beat; both low means the write is complete.
    always_comb begin
        w_wstate_nxt  = r_wstate;
        w_awready_nxt = r_awready;
        w_wready_nxt  = r_wready;
        w_bvalid_nxt  = r_bvalid;
        w_bresp_nxt   = r_bresp;
        w_we          = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (w_aw_hs) w_awready_nxt = 1'b0;
                if (w_w_hs)  w_wready_nxt  = 1'b0;
                if (!r_awready && !r_wready) begin
                    w_we         = w_wr_ok;
                    w_bvalid_nxt = 1'b1;
                    w_bresp_nxt  = w_wr_ok ? OKAY : SLVERR;
                    w_wstate_nxt = W_RESP;
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    w_bvalid_nxt  = 1'b0;
                    w_awready_nxt = 1'b1;
                    w_wready_nxt  = 1'b1;
                    w_wstate_nxt  = W_IDLE;
                end
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= OKAY;
        end else begin
            r_rstate  <= w_rstate_nxt;
            r_arready <= w_arready_nxt;
            r_rvalid  <= w_rvalid_nxt;
            r_rdata   <= w_rdata_nxt;
            r_rresp   <= w_rresp_nxt;
        end
    end

    always_comb begin
        w_rstate_nxt  = r_rstate;
        w_arready_nxt = r_arready;
        w_rvalid_nxt  = r_rvalid;
        w_rdata_nxt   = r_rdata;
        w_rresp_nxt   = r_rresp;
        case (r_rstate)
            R_IDLE: begin
                if (w_ar_hs) begin
                    w_arready_nxt = 1'b0;
                    w_rvalid_nxt  = 1'b1;
                    w_rdata_nxt   = w_rd_ok ? w_rd_word : '0;
                    w_rresp_nxt   = w_rd_ok ? OKAY : SLVERR;
                    w_rstate_nxt  = R_DATA;
                end
            end
            R_DATA: begin
                if (RREADY) begin
                    w_rvalid_nxt  = 1'b0;
                    w_arready_nxt = 1'b1;
                    w_rstate_nxt  = R_IDLE;
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    assign AWREADY = r_awready;
    assign WREADY  = r_wready;
    assign BVALID  = r_bvalid;
    assign BRESP   = r_bresp;
    assign ARREADY = r_arready;
    assign RVALID  = r_rvalid;
    assign RDATA   = r_rdata;
    assign RRESP   = r_rresp;

endmodule

`default_nettype wire

// File: tb/tb_axi4_lite_slave_regs.sv
// ============================================================================
// Module   : tb_axi4_lite_slave_regs
// Brief    : Self-checking bench for axi4_lite_slave_regs (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi4_lite_slave_regs;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NR = 16;
`ifdef AXI_LITE_SLV_PROT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic [AW-1:0] AWADDR, ARADDR;
    logic [2:0]    AWPROT, ARPROT;
    logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic          ARVALID, ARREADY, RVALID, RREADY;
    logic [DW-1:0] WDATA, RDATA;
    logic [3:0]    WSTRB;
    logic [1:0]    BRESP, RRESP;
    logic [NR*DW-1:0] regs_o;

    always #5 ACLK = ~ACLK;

    axi4_lite_slave_regs #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_REGS(NR)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .regs_o(regs_o)
    );

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] m_mem [NR];

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [1:0]  exp_bresp;
        logic [31:0] raddr;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_rresp;
    } vec_t;
    vec_t vecs [9];

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a plain word array indexed by byte address / 4.
    function automatic logic m_ok(input logic [31:0] addr, input logic [2:0] prot);
        return (addr < 32'(NR * 4)) && (prot[0] || !PROT_EN);
    endfunction

    task automatic m_write(input logic [31:0] addr, data, input logic [3:0] strb,
                           input logic [2:0] prot, output logic [1:0] resp);
        if (m_ok(addr, prot)) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) m_mem[addr / 4][8*b +: 8] = data[8*b +: 8];
            resp = 2'b00;
        end else begin
            resp = 2'b10;
        end
    endtask

    task automatic m_read(input logic [31:0] addr, input logic [2:0] prot,
                          output logic [31:0] data, output logic [1:0] resp);
        data = m_ok(addr, prot) ? m_mem[addr / 4] : 32'h0;
        resp = m_ok(addr, prot) ? 2'b00 : 2'b10;
    endtask

    function automatic logic [NR*DW-1:0] m_flat();
        logic [NR*DW-1:0] f;
        for (int i = 0; i < NR; i++) f[i*DW +: DW] = m_mem[i];
        return f;
    endfunction

    task automatic wr_issue(input logic [31:0] addr, data, input logic [3:0] strb,
                            input logic [2:0] prot);
        bit aw_done = 0;
        bit w_done = 0;
        int n = 0;
        AWADDR = addr; AWPROT = prot; WDATA = data; WSTRB = strb;
        AWVALID = 1'b1; WVALID = 1'b1;
        while (!(aw_done && w_done) && n < 50) begin
            if (AWVALID && AWREADY) aw_done = 1;
            if (WVALID && WREADY) w_done = 1;
            tick();
            n++;
            if (aw_done) AWVALID = 1'b0;
            if (w_done) WVALID = 1'b0;
        end
        AWVALID = 1'b0; WVALID = 1'b0;
        chk("wr_handshake", {aw_done, w_done}, 2'b11);
    endtask

    task automatic wait_bvalid();
        int n = 0;
        while (!BVALID && n < 50) begin tick(); n++; end
        chk("bvalid_seen", BVALID, 1'b1);
    endtask

    task automatic b_take(input int stall, output logic [1:0] resp);
        wait_bvalid();
        repeat (stall) tick();
        resp = BRESP;
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
    endtask

    task automatic axi_write(input logic [31:0] addr, data, input logic [3:0] strb,
                             input logic [2:0] prot, input int stall, output logic [1:0] resp);
        wr_issue(addr, data, strb, prot);
        b_take(stall, resp);
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [2:0] prot, input int stall,
                            output logic [31:0] data, output logic [1:0] resp);
        int n = 0;
        ARADDR = addr; ARPROT = prot; ARVALID = 1'b1;
        while (!ARREADY && n < 50) begin tick(); n++; end
        tick();
        ARVALID = 1'b0;
        n = 0;
        while (!RVALID && n < 50) begin tick(); n++; end
        chk("rvalid_seen", RVALID, 1'b1);
        repeat (stall) tick();
        data = RDATA; resp = RRESP;
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
    endtask

    // One channel is presented three cycles ahead of the other.
    task automatic split_order(input bit w_first, input logic [31:0] addr, data, spare);
        int beats = 0;
        logic [31:0] d;
        logic [1:0]  r;
        AWADDR = addr; AWPROT = 3'b001; WDATA = data; WSTRB = 4'hF;
        if (w_first) WVALID = 1'b1; else AWVALID = 1'b1;
        tick();
        WVALID = 1'b0; AWVALID = 1'b0;
        if (w_first) chk("early_w_ready", {WREADY, AWREADY}, 2'b01);
        else         chk("early_aw_ready", {WREADY, AWREADY}, 2'b10);
        tick(); tick();
        chk("early_no_b", BVALID, 1'b0);
        if (w_first) AWVALID = 1'b1; else WVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        tick();
        chk("split_b", {BVALID, BRESP}, 3'b100);
        AWADDR = spare; WDATA = ~data; AWVALID = 1'b1; WVALID = 1'b1;
        repeat (3) tick();
        chk("pending_no_capture", {AWREADY, WREADY, BVALID}, 3'b001);
        AWVALID = 1'b0; WVALID = 1'b0;
        BREADY = 1'b1;
        repeat (5) begin
            if (BVALID) beats++;
            tick();
        end
        BREADY = 1'b0;
        chk("split_b_beats", beats, 1);
        axi_read(addr, 3'b001, 0, d, r);
        chk("split_data", {d, r}, {data, 2'b00});
        axi_read(spare, 3'b001, 0, d, r);
        chk("split_spare", {d, r}, {32'h0, 2'b00});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, addr, data;
        logic [1:0]  r, er;
        logic [31:0] ed;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          beats;
        int          stall;

        vecs[0] = '{32'h04, 32'hDEADBEEF, 4'hF, 2'b00, 32'h04, 32'hDEADBEEF, 2'b00};
        vecs[1] = '{32'h08, 32'h11223344, 4'hF, 2'b00, 32'h08, 32'h11223344, 2'b00};
        vecs[2] = '{32'h08, 32'hAABBCCDD, 4'h5, 2'b00, 32'h08, 32'h11BB33DD, 2'b00};
        vecs[3] = '{32'h40, 32'h12345678, 4'hF, 2'b10, 32'h40, 32'h00000000, 2'b10};
        vecs[4] = '{32'h0E, 32'hCAFEF00D, 4'h3, 2'b00, 32'h0C, 32'h0000F00D, 2'b00};
        vecs[5] = '{32'h3C, 32'h80000001, 4'hF, 2'b00, 32'h3F, 32'h80000001, 2'b00};
        vecs[6] = '{32'hFFFFFFFC, 32'h55555555, 4'hF, 2'b10, 32'h04, 32'hDEADBEEF, 2'b00};
        vecs[7] = '{32'h04, 32'hFFFFFFFF, 4'h0, 2'b00, 32'h04, 32'hDEADBEEF, 2'b00};
        vecs[8] = '{32'h44, 32'h66666666, 4'hF, 2'b10, 32'h04, 32'hDEADBEEF, 2'b00};

        ARESET = 1'b1;
        AWADDR = '0; AWPROT = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0;
        BREADY = 1'b0; ARADDR = '0; ARPROT = '0; ARVALID = 1'b0; RREADY = 1'b0;
        for (int i = 0; i < NR; i++) m_mem[i] = '0;
        tick(); tick();
        chk("rst_ready", {AWREADY, WREADY, ARREADY, BVALID, RVALID}, 5'b11100);
        chk("rst_resp_data", {BRESP, RRESP, RDATA}, 36'h0);
        chk("rst_regs", regs_o, '0);
        ARESET = 1'b0;
        tick();

        // AW and W together: BVALID and regs_o update after the commit cycle.
        AWADDR = 32'h04; AWPROT = 3'b001; WDATA = 32'hDEADBEEF; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        chk("lat_early", {BVALID, AWREADY, WREADY}, 3'b000);
        tick();
        chk("lat_b", {BVALID, BRESP}, 3'b100);
        chk("lat_regs_o", regs_o[32 +: 32], 32'hDEADBEEF);
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        chk("lat_b_done", {BVALID, AWREADY, WREADY}, 3'b011);

        for (int i = 0; i < 9; i++) begin
            axi_write(vecs[i].waddr, vecs[i].wdata, vecs[i].strb, 3'b001, 0, r);
            chk($sformatf("vec%0d_bresp", i), r, vecs[i].exp_bresp);
            axi_read(vecs[i].raddr, 3'b001, 0, d, r);
            chk($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_rresp", i), r, vecs[i].exp_rresp);
        end

        split_order(1'b1, 32'h20, 32'h5A5A5A5A, 32'h24);
        split_order(1'b0, 32'h30, 32'hA5A5A5A5, 32'h34);

        // Read and write of the same register meet at the commit edge.
        axi_write(32'h1C, 32'h01010101, 4'hF, 3'b001, 0, r);
        AWADDR = 32'h1C; WDATA = 32'h02020202; AWVALID = 1'b1; WVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        ARADDR = 32'h1C; ARPROT = 3'b001; ARVALID = 1'b1;
        tick();
        ARVALID = 1'b0;
        chk("sim_valids", {RVALID, BVALID}, 2'b11);
        chk("sim_rdata_old", RDATA, 32'h01010101);
        BREADY = 1'b1; RREADY = 1'b1;
        tick();
        BREADY = 1'b0; RREADY = 1'b0;
        axi_read(32'h1C, 3'b001, 0, d, r);
        chk("sim_rdata_new", d, 32'h02020202);

        axi_write(32'h14, 32'h13579BDF, 4'hF, 3'b000, 0, r);
        chk("prot0_bresp", r, PROT_EN ? 2'b10 : 2'b00);
        axi_read(32'h14, 3'b001, 0, d, r);
        chk("prot0_commit", d, PROT_EN ? 32'h0 : 32'h13579BDF);
        axi_write(32'h14, 32'h2468ACE0, 4'hF, 3'b001, 0, r);
        chk("prot1_bresp", r, 2'b00);
        axi_read(32'h14, 3'b001, 0, d, r);
        chk("prot1_commit", d, 32'h2468ACE0);
        axi_read(32'h14, 3'b000, 0, d, r);
        chk("prot0_read", {d, r}, PROT_EN ? {32'h0, 2'b10} : {32'h2468ACE0, 2'b00});

        // B stalled: response held, write path blocked, reads unaffected.
        wr_issue(32'h28, 32'h77777777, 4'hF, 3'b001);
        wait_bvalid();
        for (int i = 0; i < 5; i++) begin
            chk("stall_b", {BVALID, BRESP, AWREADY, WREADY}, 5'b10000);
            tick();
        end
        axi_read(32'h04, 3'b001, 0, d, r);
        chk("stall_read", {d, r}, {32'hDEADBEEF, 2'b00});
        chk("stall_b_held", BVALID, 1'b1);
        b_take(0, r);
        chk("stall_bresp", r, 2'b00);

        // Reset while a response is pending drops it.
        wr_issue(32'h2C, 32'h99999999, 4'hF, 3'b001);
        wait_bvalid();
        tick(); tick();
        ARESET = 1'b1;
        tick();
        chk("midrst_bvalid", BVALID, 1'b0);
        chk("midrst_regs", regs_o, '0);
        chk("midrst_ready", {AWREADY, WREADY, ARREADY, RVALID}, 4'b1110);
        ARESET = 1'b0;
        BREADY = 1'b1;
        beats = 0;
        repeat (4) begin
            if (BVALID) beats++;
            tick();
        end
        BREADY = 1'b0;
        chk("midrst_no_b", beats, 0);
        for (int i = 0; i < NR; i++) m_mem[i] = '0;

        for (int i = 0; i < 300; i++) begin
            addr  = $urandom_range(0, 32'h4F);
            prot  = 3'($urandom_range(0, 7));
            stall = $urandom_range(0, 2);
            if ($urandom_range(0, 1) == 1) begin
                data = $urandom;
                strb = 4'($urandom_range(0, 15));
                axi_write(addr, data, strb, prot, stall, r);
                m_write(addr, data, strb, prot, er);
                chk("rnd_bresp", r, er);
            end else begin
                axi_read(addr, prot, stall, d, r);
                m_read(addr, prot, ed, er);
                chk("rnd_rdata", d, ed);
                chk("rnd_rresp", r, er);
            end
        end
        tick();
        chk("final_regs", regs_o, m_flat());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axi4_lite_slave_regs.md
Name: axi4_lite_slave_regs

Overview:
- AXI4-Lite slave register file. Sits directly downstream of the team's AXI4-Lite master and terminates its AW/W/B and AR/R channels.
- Holds NUM_REGS word-wide software registers with byte-strobe writes, an OKAY/SLVERR response scheme, and independent read and write paths.
- Register contents are exported to the surrounding logic.

Parameters:
- DATA_WIDTH, 32: data bus width in bits; must be 32 or 64.
- ADDRESS_WIDTH, 32: address bus width in bits.
- NUM_REGS, 16: number of registers; power of two, at least 2.

Ports:
- ACLK  in  1  sole clock.
- ARESET  in  1  reset, synchronous and active-high.
- AWADDR  in  ADDRESS_WIDTH  write address.
- AWPROT  in  3  write protection.
- AWVALID  in  1 / AWREADY  out  1  write-address handshake.
- WDATA  in  DATA_WIDTH / WSTRB  in  DATA_WIDTH/8  write data and byte strobes.
- WVALID  in  1 / WREADY  out  1  write-data handshake.
- BRESP  out  2 / BVALID  out  1 / BREADY  in  1  write response channel.
- ARADDR  in  ADDRESS_WIDTH / ARPROT  in  3  read address and protection.
- ARVALID  in  1 / ARREADY  out  1  read-address handshake.
- RDATA  out  DATA_WIDTH / RRESP  out  2 / RVALID  out  1 / RREADY  in  1  read data channel.
- regs_o  out  NUM_REGS*DATA_WIDTH  flattened register contents; reg i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Reset: ARESET is sampled on the ACLK rising edge and overrides everything.
  - Outputs and state: AWREADY=1, WREADY=1, ARREADY=1, BVALID=0, RVALID=0, BRESP=0, RRESP=0, RDATA=0, all regs=0, write FSM=W_IDLE, read FSM=R_IDLE.
  - Reset mid-transaction drops the transaction silently: no B or R beat is ever issued for it.
- Address decode:
  - Word index = addr[log2(DATA_WIDTH/8) +: log2(NUM_REGS)].
  - The address is in range when addr < NUM_REGS*DATA_WIDTH/8.
  - Low byte-offset bits are ignored.
- Write FSM states: W_IDLE, W_RESP.
  - AW and W are captured independently, in either order or in the same cycle.
  - AWREADY deasserts the cycle after the AW handshake and stays low until the B handshake. WREADY behaves the same way for W.
  - Once both AW and W are captured (at the earliest the cycle after the later handshake):
    - Commit the write: byte k is updated only where WSTRB[k]=1.
    - Set BVALID=1 and BRESP=OKAY (2'b00), then enter W_RESP.
  - Out-of-range address: no register changes, BRESP=SLVERR (2'b10).
  - In W_RESP, BVALID and BRESP stay stable until BREADY=1. In the handshake cycle: BVALID=0, AWREADY=WREADY=1, next state W_IDLE.
  - Latency: AW and W in the same cycle gives BVALID 1 cycle later. Minimum write turnaround is 3 cycles.
- Read FSM states: R_IDLE, R_DATA.
  - On AR handshake in R_IDLE: ARREADY=0 next cycle, RVALID=1, RDATA=reg[idx], RRESP=OKAY. Out of range: RDATA=0, RRESP=SLVERR.
  - RDATA and RRESP are held stable until RREADY. In the handshake cycle: RVALID=0, ARREADY=1.
- Simultaneous read and write to the same register: the read samples the pre-commit value. A read in a later cycle sees the new value.
- BREADY or RREADY held low indefinitely stalls only its own channel. The other channel keeps operating.
- regs_o reflects the committed value one cycle after commit (registered outputs).
- VALID outputs never depend combinationally on READY inputs.

Optional Feature:
- Macro: AXI_LITE_SLV_PROT_EN.
- Defined:
  - A write with AWPROT[0]=0 (unprivileged) is not committed and returns BRESP=SLVERR.
  - A read with ARPROT[0]=0 returns RDATA=0 and RRESP=SLVERR.
  - Privileged accesses (PROT[0]=1, as the team's master issues) behave normally.
- Undefined: AWPROT and ARPROT are ignored.

Decomposition:
- Package axi4_lite_pkg holds:
  - resp_t enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - Write FSM enum w_state_t and read FSM enum r_state_t.
  - Localparams for PROT bit positions.
- Sub-module axi4_lite_regfile: storage array with a strobed write port and one combinational read port. The FSMs stay in the top module.

Test Plan:
- Write 0xDEADBEEF to 0x04 with WSTRB=4'hF, AW and W in the same cycle, BREADY=1 -> BVALID 1 cycle later, BRESP=00. Read 0x04 -> RDATA=0xDEADBEEF, RRESP=00.
- Preload 0x11223344 at 0x08, then write 0xAABBCCDD with WSTRB=4'b0101 -> read returns 0x11BB33DD.
- W sent 3 cycles before AW, and separately AW sent 3 cycles before W -> exactly one B beat each time, correct data committed, no second capture while the response is pending.
- Write to 0x40 with NUM_REGS=16 -> BRESP=10 and all regs unchanged. Read from 0x40 -> RDATA=0, RRESP=10.
- Hold BREADY=0 for 5 cycles -> BVALID and BRESP stable throughout, AWREADY=0. Reads still complete. Assert ARESET in cycle 3 -> BVALID=0 and all regs=0 the next cycle.
- With AXI_LITE_SLV_PROT_EN: write with AWPROT=3'b000 -> SLVERR and no commit. Write with AWPROT=3'b001 -> OKAY and committed. Without the macro: both writes commit.
